// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mul_sequencer
//  Purpose  : Iterative radix-2 shift-add multiplier with register-file
//             writeback sequencing for MUL, UMULL and SMULL.
//  Ports    : clk, reset (sync, active-low)
//             start, op[2:0], a, b         -- request (sampled in IDLE only)
//             busy                         -- high outside IDLE
//             wr_en, wr_sel, wr_data       -- register-file write port
//             result_lo, result_hi         -- product words
//             flag_n, flag_z, done         -- flags, completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic             done
);

    localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0]       C_OP_MUL   = 3'b100;
    localparam logic [2:0]       C_OP_UMULL = 3'b101;
    localparam logic [2:0]       C_OP_SMULL = 3'b110;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_FIX  = 3'd2,
        S_WBLO = 3'd3,
        S_WBHI = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_long;

    logic                 w_op_valid;
    logic                 w_is_smull;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic [2*WIDTH-1:0]   w_fixed;

    assign w_op_valid = (op == C_OP_MUL) || (op == C_OP_UMULL) || (op == C_OP_SMULL);
    assign w_is_smull = (op == C_OP_SMULL);

    // Signed long multiply works on magnitudes; the sign is reapplied in FIX.
    // The most negative value maps to itself, which is correct as unsigned.
    assign w_mag_a = (w_is_smull && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_mag_b = (w_is_smull && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_fixed    = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_long    <= 1'b0;
            busy      <= 1'b0;
            wr_en     <= 1'b0;
            wr_sel    <= 1'b0;
            wr_data   <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_op_valid) begin
                        r_state  <= S_MULT;
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_is_smull & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_long   <= (op != C_OP_MUL);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                    end
                end

                S_MULT: begin
                    r_acc    <= w_acc_step;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    r_acc     <= w_fixed;
                    result_lo <= w_fixed[WIDTH-1:0];
                    result_hi <= r_long ? w_fixed[2*WIDTH-1:WIDTH] : '0;
                    if (r_long) begin
                        flag_n <= w_fixed[2*WIDTH-1];
                        flag_z <= (w_fixed == '0);
                    end else begin
                        flag_n <= w_fixed[WIDTH-1];
                        flag_z <= (w_fixed[WIDTH-1:0] == '0);
                    end
                    // Outputs for the low-word write are set up as WBLO is entered.
                    r_state <= S_WBLO;
                    wr_en   <= 1'b1;
                    wr_sel  <= 1'b0;
                    wr_data <= w_fixed[WIDTH-1:0];
                end

                S_WBLO: begin
                    if (r_long) begin
                        r_state <= S_WBHI;
                        wr_en   <= 1'b1;
                        wr_sel  <= 1'b1;
                        wr_data <= result_hi;
                    end else begin
                        r_state <= S_DONE;
                        wr_en   <= 1'b0;
                        wr_sel  <= 1'b0;
                        wr_data <= '0;
                        done    <= 1'b1;
                    end
                end

                S_WBHI: begin
                    r_state <= S_DONE;
                    wr_en   <= 1'b0;
                    wr_sel  <= 1'b0;
                    wr_data <= '0;
                    done    <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    wr_en   <= 1'b0;
                    wr_sel  <= 1'b0;
                    wr_data <= '0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_sequencer
//  Purpose  : Scoreboard testbench for mul_sequencer (WIDTH = 32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        flag_n;
    logic        flag_z;
    logic        done;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .done      (done)
    );

    typedef struct {
        bit          is_done;
        int          cyc;
        logic        sel;
        logic [31:0] data;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        n;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe or done pulse is matched against the queue.
    always @(negedge clk) begin
        if (wr_en || done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got wr_en=%0b done=%0b expected nothing (cycle %0d)",
                         wr_en, done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("kind_done", {63'b0, done}, {63'b0, e.is_done});
                chk("cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_done) begin
                    chk("result_lo", 64'(result_lo), 64'(e.lo));
                    chk("result_hi", 64'(result_hi), 64'(e.hi));
                    chk("flag_n", {63'b0, flag_n}, {63'b0, e.n});
                    chk("flag_z", {63'b0, flag_z}, {63'b0, e.z});
                end else begin
                    chk("wr_sel", {63'b0, wr_sel}, {63'b0, e.sel});
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                end
            end
        end
    end

    // Issue one operation at the current negedge (cycle 0), push its expected
    // writes/done, and return at the negedge of the cycle busy drops, so the
    // next call starts back-to-back. poke>0 pulses a stray start at c0+poke.
    task automatic run(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic en, input logic ez, input int poke);
        int   c0;
        int   t_idle;
        bit   lng;
        exp_t e;
        lng    = (o != 3'b100);
        c0     = cyc;
        t_idle = c0 + (lng ? 37 : 36);
        op     = o;
        a      = ia;
        b      = ib;
        start  = 1'b1;
        e.is_done = 1'b0; e.cyc = c0 + 34; e.sel = 1'b0; e.data = elo;
        e.lo = elo; e.hi = ehi; e.n = en; e.z = ez;
        sb.push_back(e);
        if (lng) begin
            e.cyc = c0 + 35; e.sel = 1'b1; e.data = ehi;
            sb.push_back(e);
        end
        e.is_done = 1'b1; e.cyc = c0 + (lng ? 36 : 35);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", {63'b0, busy}, 64'd1);
        while (cyc < t_idle) begin
            @(negedge clk);
            if (poke > 0 && cyc == c0 + poke) begin
                start = 1'b1;
                op    = 3'b100;
                a     = 32'h0000_0055;
                b     = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_fall", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int c0;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_results", {result_hi, result_lo}, 64'd0);
        chk("rst_flags", {62'b0, flag_n, flag_z}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        //   op      a             b             lo            hi            n     z     poke
        run(3'b100, 32'd7,        32'd6,        32'd42,       32'd0,        1'b0, 1'b0, 0);
        run(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 0);
        run(3'b110, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        run(3'b110, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 0);
        run(3'b100, 32'h12345678, 32'd0,        32'h00000000, 32'd0,        1'b0, 1'b1, 0);
        run(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);
        run(3'b101, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0, 1'b1, 0);
        run(3'b101, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 10);
        run(3'b100, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd0,        1'b1, 1'b0, 0);
        run(3'b110, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 32'hFFFFFFFF, 1'b1, 1'b0, 0);

        // Reset in the middle of a SMULL: nothing may come out of it.
        c0    = cyc;
        op    = 3'b110;
        a     = 32'hFFFFFFF0;
        b     = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_results", {result_hi, result_lo}, 64'd0);
        chk("midrst_flags", {62'b0, flag_n, flag_z}, 64'd0);
        chk("midrst_wr_en", {63'b0, wr_en}, 64'd0);
        repeat (40) @(negedge clk);
        chk("midrst_idle", {63'b0, busy}, 64'd0);

        run(3'b100, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 1'b0, 0);

        // Invalid opcode must be ignored entirely.
        op    = 3'b011;
        a     = 32'd4;
        b     = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("badop_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("badop_busy_late", {63'b0, busy}, 64'd0);
        chk("badop_results", 64'(result_lo), 64'd9);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative multiply unit and writeback sequencer for the multicycle ARM core. It executes MUL, UMULL and SMULL as a radix-2 shift-add operation over WIDTH cycles, using the ALU's multiply opcodes. It then drives the register-file write port for one result word (MUL) or two result words (UMULL/SMULL: RdLo, then RdHi). The main FSM holds in its execute state while `busy` is high, and takes the N/Z flag update from `done`.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; 0 sampled at a rising edge resets the block.
- start  input  1  request; sampled only in IDLE.
- op  input  3  ALUControl encoding: 3'b100 MUL, 3'b101 UMULL, 3'b110 SMULL.
- a  input  WIDTH  multiplicand (Rn).
- b  input  WIDTH  multiplier (Rm).
- busy  output  1  high in every state except IDLE.
- wr_en  output  1  register-file write strobe, one cycle per result word.
- wr_sel  output  1  0 = low word / Rd, 1 = high word / RdHi; valid while wr_en is high.
- wr_data  output  WIDTH  word being written; equals result_lo or result_hi per wr_sel.
- result_lo  output  WIDTH  low product word; held until the next accepted start.
- result_hi  output  WIDTH  high product word; 0 for MUL.
- flag_n  output  1  sign of the result (bit WIDTH-1 for MUL, bit 2*WIDTH-1 for long ops).
- flag_z  output  1  result is zero (low word for MUL, all 2*WIDTH bits for long ops).
- done  output  1  one-cycle completion pulse; flags are valid in this cycle.

## Operation
- States: IDLE, MULT, FIX, WBLO, WBHI, DONE.
- IDLE, start=1, op valid: accept the request and move to MULT.
  - Capture mcand = |a| and mplier = |b|. Magnitudes apply for SMULL only; MUL and UMULL take raw operands.
  - Set neg = a[W-1]^b[W-1] for SMULL, 0 otherwise.
  - Clear acc (2W bits) and cnt.
- IDLE, start=1, op not in {100,101,110}: ignore the request, stay in IDLE, no write.
- IDLE, start=0: stay in IDLE.
- Magnitude is the W-bit two's-complement negate, treated as unsigned. |0x80000000| = 0x80000000.
- MULT, each cycle:
  - if mplier[0], acc += mcand zero-extended to 2W bits;
  - mcand <<= 1 in a 2W-bit register;
  - mplier >>= 1;
  - cnt++.
  - Leave for FIX after the cycle in which cnt = W-1, i.e. after exactly W cycles.
- FIX: acc = neg ? (~acc + 1) mod 2^(2W) : acc.
  - Load result_lo = acc[W-1:0].
  - Load result_hi = long ? acc[2W-1:W] : 0.
  - Compute flag_n and flag_z. → WBLO.
- WBLO: wr_en=1, wr_sel=0. → WBHI if op is long, else → DONE.
- WBHI: wr_en=1, wr_sel=1. → DONE.
- DONE: done=1. → IDLE.
- start in any state other than IDLE is ignored and has no side effects.
- MUL low word is identical for signed and unsigned operands; no sign correction is applied.
- Reset (reset=0 at an edge), including in the middle of an operation:
  - state → IDLE;
  - acc, mcand, mplier, cnt, result_lo, result_hi, flag_n, flag_z → 0;
  - the aborted operation produces no wr_en and no done.
- Output reset values: busy, wr_en, wr_sel, done, flag_n, flag_z all 0; wr_data, result_lo, result_hi all 0.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- Cycle 0 is the cycle in which start is sampled high in IDLE.
  - busy is high from cycle 1.
  - MULT occupies cycles 1..W; FIX is cycle W+1.
  - WBLO is cycle W+2.
  - MUL: DONE is cycle W+3, back in IDLE at W+4.
  - Long ops: WBHI is cycle W+3, DONE is cycle W+4, back in IDLE at W+5.
- Latency for WIDTH=32:
  - MUL: write at 34, done at 35.
  - UMULL/SMULL: writes at 34 and 35, done at 36.
- busy drops in the cycle after DONE. A new start may be sampled in that same cycle (back-to-back operation).
- result_lo, result_hi and the flags are stable from cycle W+2 until the next accepted start.

## Test plan
- MUL, a=7, b=6 → wr_en only at cycle 34 with wr_sel=0, wr_data=42; done at 35; result_hi=0; n=0, z=0.
- UMULL, a=b=0xFFFFFFFF → cycle 34: wr_data=0x00000001 (sel 0); cycle 35: wr_data=0xFFFFFFFE (sel 1); done at 36; n=1.
- SMULL, a=0xFFFFFFFD (-3), b=5 → lo=0xFFFFFFF1, hi=0xFFFFFFFF, n=1, z=0. SMULL, a=b=0x80000000 → hi=0x40000000, lo=0, n=0.
- MUL, a=0x12345678, b=0 → lo=0, z=1, single write. Invalid op 3'b011 with start=1 → busy stays 0, no wr_en, no done.
- start pulsed at cycle 10 of a running UMULL → ignored; the original result completes on schedule. Back-to-back start in the cycle busy drops → second operation accepted.
- reset=0 at cycle 20 of a SMULL → from cycle 21: busy=0, results 0, no wr_en and no done afterwards. A following MUL 3×3 yields 9 normally.
